// File: rtl/fir_serial_sequencer.sv
// Serial FIR sequencer: sample ring buffer plus one shared MAC stepping one tap per cycle, valid/ready on both sides.
// Result appears TAP_COUNT+1 cycles after the input handshake; define FIR_SAT_EN to clamp data_out instead of wrapping.
module fir_serial_sequencer #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int TAP_WIDTH      = 24,
  parameter int TAP_COUNT      = 54,
  parameter int DATA_OUT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_IN_WIDTH-1:0]     data_in,
  output logic [$clog2(TAP_COUNT)-1:0] tap_addr,
  input  logic [TAP_WIDTH-1:0]         tap_coef,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_OUT_WIDTH-1:0]    data_out,
  output logic                         busy
);

  localparam int AW    = $clog2(TAP_COUNT);
  localparam int PW    = DATA_IN_WIDTH + TAP_WIDTH;
  localparam int ACC_W = DATA_IN_WIDTH + TAP_WIDTH + AW;
  localparam logic [AW-1:0] LAST = AW'(TAP_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic signed [DATA_IN_WIDTH-1:0]  r_buf [TAP_COUNT];
  logic        [AW-1:0]             r_wr_ptr;
  logic        [AW-1:0]             r_base;
  logic        [AW-1:0]             r_k;
  logic signed [ACC_W-1:0]          r_acc;
  logic        [DATA_OUT_WIDTH-1:0] r_dout;

  logic        [AW-1:0]             w_rd_idx;
  logic signed [DATA_IN_WIDTH-1:0]  w_sample;
  logic signed [PW-1:0]             w_prod;
  logic signed [ACC_W-1:0]          w_acc_next;
  logic        [DATA_OUT_WIDTH-1:0] w_conv;

  logic                             w_in_ready;
  logic                             w_out_valid;
  logic                             w_busy;
  logic        [AW-1:0]             w_tap_addr;

  // Newest sample sits at base; older samples are found by stepping backwards with wrap.
  assign w_rd_idx   = (r_base >= r_k) ? (r_base - r_k)
                    : AW'({1'b0, r_base} + (AW+1)'(TAP_COUNT) - {1'b0, r_k});
  assign w_sample   = r_buf[w_rd_idx];
  assign w_prod     = w_sample * $signed(tap_coef);
  assign w_acc_next = r_acc + ACC_W'(w_prod);

  generate
    if (DATA_OUT_WIDTH >= ACC_W) begin : g_out_ext
      assign w_conv = DATA_OUT_WIDTH'(w_acc_next);
    end else begin : g_out_narrow
`ifdef FIR_SAT_EN
      localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};
      assign w_conv = (w_acc_next > SAT_MAX) ? SAT_MAX[DATA_OUT_WIDTH-1:0]
                    : (w_acc_next < SAT_MIN) ? SAT_MIN[DATA_OUT_WIDTH-1:0]
                    : w_acc_next[DATA_OUT_WIDTH-1:0];
`else
      assign w_conv = w_acc_next[DATA_OUT_WIDTH-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid)     w_next_state = S_MAC;
        S_MAC:   if (r_k == LAST)  w_next_state = S_HOLD;
        S_HOLD:  if (out_ready)    w_next_state = S_IDLE;
        default:                   w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    w_tap_addr  = '0;
    case (r_state)
      S_IDLE:  w_in_ready = ~reset;
      S_MAC: begin
        w_busy     = 1'b1;
        w_tap_addr = r_k;
      end
      S_HOLD:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign busy      = w_busy;
  assign tap_addr  = w_tap_addr;
  assign data_out  = r_dout;

  // clear behaves like a synchronous reset of the whole datapath, including pending results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAP_COUNT; i++) r_buf[i] <= '0;
      r_wr_ptr <= '0;
      r_base   <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_dout   <= '0;
    end else if (clear) begin
      for (int i = 0; i < TAP_COUNT; i++) r_buf[i] <= '0;
      r_wr_ptr <= '0;
      r_base   <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_dout   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_buf[r_wr_ptr] <= data_in;
            r_base          <= r_wr_ptr;
            r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + AW'(1);
            r_acc           <= '0;
            r_k             <= '0;
          end
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          if (r_k == LAST) begin
            r_dout <= w_conv;
          end else begin
            r_k <= r_k + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_sequencer.sv
// Self-checking bench for fir_serial_sequencer with TAP_COUNT=4; reference model is a plain history-array dot product.
module tb_fir_serial_sequencer;

  localparam int DIN  = 16;
  localparam int TW   = 24;
  localparam int N    = 4;
  localparam int DOUT = 32;
  localparam int AW   = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic [DIN-1:0]  data_in;
  logic [AW-1:0]   tap_addr;
  logic [TW-1:0]   tap_coef;
  logic            out_valid;
  logic            out_ready;
  logic [DOUT-1:0] data_out;
  logic            busy;

  logic signed [TW-1:0] taps [N];
  longint               hist [N];
  int                   n_assert = 0;
  int                   n_fail   = 0;

  fir_serial_sequencer #(
    .DATA_IN_WIDTH (DIN),
    .TAP_WIDTH     (TW),
    .TAP_COUNT     (N),
    .DATA_OUT_WIDTH(DOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .tap_addr (tap_addr),
    .tap_coef (tap_coef),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .busy     (busy)
  );

  assign tap_coef = taps[tap_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_taps(input longint a, input longint b, input longint c, input longint d);
    taps[0] = TW'(a);
    taps[1] = TW'(b);
    taps[2] = TW'(c);
    taps[3] = TW'(d);
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) hist[i] = 0;
  endtask

  task automatic model_push(input logic signed [DIN-1:0] x);
    for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = longint'(x);
  endtask

  function automatic logic signed [DOUT-1:0] model_out();
    longint acc;
    acc = 0;
    for (int i = 0; i < N; i++) acc += longint'(taps[i]) * hist[i];
`ifdef FIR_SAT_EN
    if (acc > 64'sd2147483647) acc = 64'sd2147483647;
    if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`endif
    return acc[DOUT-1:0];
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic send(input logic signed [DIN-1:0] x, input int hold, input string tag);
    logic signed [DOUT-1:0] exp;
    int cnt;
    bit seen;
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    chk({tag, "_out_valid_idle"}, out_valid, 0);
    model_push(x);
    exp       = model_out();
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    data_in   = x;
    @(negedge clk);
    in_valid = 1'b0;
    cnt  = 1;
    seen = 1'b0;
    while (!seen && cnt <= N + 6) begin
      if (out_valid) begin
        seen = 1'b1;
      end else begin
        if (cnt <= N) begin
          chk({tag, "_tap_addr"}, tap_addr, cnt - 1);
          chk({tag, "_busy"}, busy, 1);
          chk({tag, "_in_ready_mac"}, in_ready, 0);
        end
        data_in = DIN'($urandom);
        @(negedge clk);
        cnt++;
      end
    end
    chk({tag, "_latency"}, seen ? cnt : -1, N + 1);
    if (seen) begin
      chk({tag, "_data_out"}, $signed(data_out), exp);
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        data_in  = DIN'($urandom);
        @(negedge clk);
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_data"}, $signed(data_out), exp);
        chk({tag, "_hold_in_ready"}, in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_released"}, out_valid, 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    set_taps(1, 2, 3, 4);
    model_clear();

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tap_addr", tap_addr, 0);
    chk("rst_data_out", $signed(data_out), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Impulse then a step long enough to wrap the write pointer more than twice.
    send(1, 0, "imp");
    repeat (4) send(0, 0, "imp");
    repeat (10) send(100, 0, "step");

    send(16'sd1234, 20, "bp");

    // clear wins over a simultaneous sample in IDLE.
    clear    = 1'b1;
    in_valid = 1'b1;
    data_in  = 16'd555;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_idle_in_ready", in_ready, 1);
    chk("clr_idle_busy", busy, 0);
    chk("clr_idle_out_valid", out_valid, 0);
    model_clear();
    send(1, 0, "clr_imp");
    repeat (3) send(0, 0, "clr_imp");

    // Reset while the MAC is on tap 2.
    in_valid = 1'b1;
    data_in  = 16'sd77;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_mac_tap_addr", tap_addr, 2);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_tap_addr", tap_addr, 0);
    chk("mid_rst_data_out", $signed(data_out), 0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(1, 0, "rst_imp");

    // clear during MAC discards the computation.
    in_valid = 1'b1;
    data_in  = 16'sd500;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_mac_busy", busy, 0);
    chk("clr_mac_in_ready", in_ready, 1);
    repeat (N + 2) @(negedge clk);
    chk("clr_mac_no_result", out_valid, 0);
    model_clear();

    // clear during HOLD drops the pending result.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 16'sd321;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < N + 6 && !out_valid; i++) @(negedge clk);
    chk("clr_hold_reached", out_valid, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_hold_out_valid", out_valid, 0);
    chk("clr_hold_data_out", $signed(data_out), 0);
    chk("clr_hold_in_ready", in_ready, 1);
    model_clear();
    send(1, 0, "clr_hold_imp");

    // Full-scale products: saturates with FIR_SAT_EN, wraps otherwise.
    set_taps(8388607, 8388607, 8388607, 8388607);
    repeat (4) send(16'sd32767, 0, "sat");

    for (int r = 0; r < 12; r++) begin
      set_taps(longint'($signed(TW'($urandom))), longint'($signed(TW'($urandom))),
               longint'($signed(TW'($urandom))), longint'($signed(TW'($urandom))));
      send(DIN'($urandom), $urandom_range(0, 3), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
